// File: rtl/ftdi_fifo_bridge.sv
// ftdi_fifo_bridge: FT245-style asynchronous FIFO-interface master.
// Buffers FTDI->local traffic in an RX FIFO and local->FTDI traffic in a
// TX FIFO, and alternates fairly between read and write bursts on the pins.
// Optional macro FTDI_INPUT_SYNC_EN: double-flop rxf_n/txe_n and stretch
// the recovery window by the synchroniser latency.
module ftdi_fifo_bridge #(
  parameter int DATA_W         = 8,
  parameter int RX_DEPTH       = 16,
  parameter int TX_DEPTH       = 16,
  parameter int RD_CYCLES      = 2,
  parameter int WR_CYCLES      = 2,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxf_n,
  input  logic                          txe_n,
  output logic                          oe_n,
  output logic                          rd_n,
  output logic                          wr_n,
  input  logic [DATA_W-1:0]             ftdi_din,
  output logic [DATA_W-1:0]             ftdi_dout,
  output logic                          ftdi_dout_en,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(RX_DEPTH+1)-1:0] rx_level,
  output logic [$clog2(TX_DEPTH+1)-1:0] tx_level,
  output logic                          rx_overflow
);

  localparam int RXL_W = $clog2(RX_DEPTH + 1);
  localparam int TXL_W = $clog2(TX_DEPTH + 1);
  localparam int RXA_W = $clog2(RX_DEPTH);
  localparam int TXA_W = $clog2(TX_DEPTH);

`ifdef FTDI_INPUT_SYNC_EN
  localparam int SYNC_EXTRA = 2;
`else
  localparam int SYNC_EXTRA = 0;
`endif

  localparam int REC_CYC = RECOVER_CYCLES + SYNC_EXTRA;
  localparam int MAX_A   = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int MAX_C   = (MAX_A > REC_CYC) ? MAX_A : REC_CYC;
  localparam int CNT_W   = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(REC_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  localparam logic [RXL_W-1:0] RX_FULL_LVL   = RXL_W'(RX_DEPTH);
  localparam logic [RXL_W-1:0] RX_ALMOST_LVL = RXL_W'(RX_DEPTH - 1);
  localparam logic [TXL_W-1:0] TX_FULL_LVL   = TXL_W'(TX_DEPTH);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_OE      = 3'd1,
    RD_STROBE  = 3'd2,
    RD_RECOVER = 3'd3,
    WR_SETUP   = 3'd4,
    WR_STROBE  = 3'd5,
    WR_RECOVER = 3'd6
  } state_e;

  typedef enum logic {
    GRANT_RX = 1'b0,
    GRANT_TX = 1'b1
  } grant_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  grant_e              last_grant_q, grant_d;
  logic                oe_n_q, oe_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic                dout_en_q, dout_en_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [DATA_W-1:0]   cap_q;
  logic                cap_vld_q;
  logic                overflow_q;
  logic                cap_en_s, tx_pop_s, launch_s;
  logic                rxf_s, txe_s, rx_req_s, tx_req_s, pick_rx_s, pick_tx_s;

  // RX FIFO storage and control
  logic [DATA_W-1:0]   rx_mem_q [RX_DEPTH];
  logic [RXA_W-1:0]    rx_wr_ptr_q, rx_rd_ptr_q;
  logic [RXL_W-1:0]    rx_level_q, rx_level_d;
  logic                rx_full_s, rx_empty_s, rx_pop_s, rx_wr_en_s;

  // TX FIFO storage and control
  logic [DATA_W-1:0]   tx_mem_q [TX_DEPTH];
  logic [TXA_W-1:0]    tx_wr_ptr_q, tx_rd_ptr_q;
  logic [TXL_W-1:0]    tx_level_q, tx_level_d;
  logic                tx_full_s, tx_empty_s, tx_push_s, tx_rd_en_s;

`ifdef FTDI_INPUT_SYNC_EN
  logic [1:0] rxf_sync_q, txe_sync_q;

  // Two-flop synchronisers for the asynchronous FTDI status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxf_sync_q <= 2'b11;
      txe_sync_q <= 2'b11;
    end else begin
      rxf_sync_q <= {rxf_sync_q[0], rxf_n};
      txe_sync_q <= {txe_sync_q[0], txe_n};
    end
  end

  assign rxf_s = rxf_sync_q[1];
  assign txe_s = txe_sync_q[1];
`else
  assign rxf_s = rxf_n;
  assign txe_s = txe_n;
`endif

  // FIFO status and handshakes
  assign rx_full_s  = (rx_level_q == RX_FULL_LVL);
  assign rx_empty_s = (rx_level_q == {RXL_W{1'b0}});
  assign rx_pop_s   = rx_ready && !rx_empty_s;
  assign rx_wr_en_s = cap_vld_q && (!rx_full_s || rx_pop_s);
  assign tx_full_s  = (tx_level_q == TX_FULL_LVL);
  assign tx_empty_s = (tx_level_q == {TXL_W{1'b0}});
  assign tx_push_s  = tx_valid && !tx_full_s;
  assign tx_rd_en_s = tx_pop_s && !tx_empty_s;

  // Request qualification; a word still in the capture register already owns a slot
  always_comb begin
    rx_req_s  = 1'b0;
    pick_rx_s = 1'b0;
    pick_tx_s = 1'b0;
    if (cap_vld_q) begin
      rx_req_s = !rxf_s && (rx_level_q < RX_ALMOST_LVL);
    end else begin
      rx_req_s = !rxf_s && (rx_level_q < RX_FULL_LVL);
    end
    tx_req_s = !txe_s && !tx_empty_s;
    if (rx_req_s && (!tx_req_s || (last_grant_q == GRANT_TX))) begin
      pick_rx_s = 1'b1;
    end else begin
      pick_tx_s = tx_req_s;
    end
  end

  // Next-state logic for the pin sequencer
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_d  = last_grant_q;
    tx_pop_s = 1'b0;
    cap_en_s = 1'b0;
    launch_s = 1'b0;
    case (state_q)
      IDLE: launch_s = 1'b1;
      RD_OE: begin
        state_d = RD_STROBE;
        cnt_d   = CNT_ZERO;
      end
      RD_STROBE: begin
        if (cnt_q == RD_LAST) begin
          cap_en_s = 1'b1;
          state_d  = RD_RECOVER;
          cnt_d    = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_RECOVER: begin
        if (cnt_q == REC_LAST) begin
          launch_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_SETUP: begin
        state_d = WR_STROBE;
        cnt_d   = CNT_ZERO;
      end
      WR_STROBE: begin
        if (cnt_q == WR_LAST) begin
          state_d = WR_RECOVER;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_RECOVER: begin
        if (cnt_q != REC_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if ((REC_CYC == 1) && pick_rx_s) begin
          // a one-clock recovery leaves no idle gap before oe_n, so pass through IDLE
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          launch_s = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
    if (launch_s) begin
      cnt_d = CNT_ZERO;
      if (pick_rx_s) begin
        state_d = RD_OE;
        grant_d = GRANT_RX;
      end else if (pick_tx_s) begin
        state_d  = WR_SETUP;
        grant_d  = GRANT_TX;
        tx_pop_s = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end else begin
      tx_pop_s = 1'b0;
    end
  end

  // Pin decode from the upcoming state so strobes leave flops directly
  always_comb begin
    oe_n_d    = 1'b1;
    rd_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    dout_en_d = 1'b0;
    case (state_d)
      RD_OE:      oe_n_d = 1'b0;
      RD_STROBE: begin
        oe_n_d = 1'b0;
        rd_n_d = 1'b0;
      end
      WR_SETUP:   dout_en_d = 1'b1;
      WR_STROBE: begin
        dout_en_d = 1'b1;
        wr_n_d    = 1'b0;
      end
      WR_RECOVER: dout_en_d = (cnt_d == CNT_ZERO);
      default:    dout_en_d = 1'b0;
    endcase
    if (tx_pop_s) begin
      dout_d = tx_mem_q[tx_rd_ptr_q];
    end else begin
      dout_d = dout_q;
    end
  end

  // Sequencer state, pin registers, capture register and overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= CNT_ZERO;
      last_grant_q <= GRANT_TX;
      oe_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      dout_en_q    <= 1'b0;
      dout_q       <= {DATA_W{1'b0}};
      cap_q        <= {DATA_W{1'b0}};
      cap_vld_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= grant_d;
      oe_n_q       <= oe_n_d;
      rd_n_q       <= rd_n_d;
      wr_n_q       <= wr_n_d;
      dout_en_q    <= dout_en_d;
      dout_q       <= dout_d;
      cap_vld_q    <= cap_en_s;
      if (cap_en_s) begin
        cap_q <= ftdi_din;
      end
      if (cap_vld_q && rx_full_s && !rx_pop_s) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Occupancy next-state for both FIFOs
  always_comb begin
    rx_level_d = rx_level_q;
    tx_level_d = tx_level_q;
    case ({rx_wr_en_s, rx_pop_s})
      2'b10:   rx_level_d = rx_level_q + RXL_W'(1);
      2'b01:   rx_level_d = rx_level_q - RXL_W'(1);
      default: rx_level_d = rx_level_q;
    endcase
    case ({tx_push_s, tx_rd_en_s})
      2'b10:   tx_level_d = tx_level_q + TXL_W'(1);
      2'b01:   tx_level_d = tx_level_q - TXL_W'(1);
      default: tx_level_d = tx_level_q;
    endcase
  end

  // FIFO pointers and levels; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_ptr_q <= {RXA_W{1'b0}};
      rx_rd_ptr_q <= {RXA_W{1'b0}};
      rx_level_q  <= {RXL_W{1'b0}};
      tx_wr_ptr_q <= {TXA_W{1'b0}};
      tx_rd_ptr_q <= {TXA_W{1'b0}};
      tx_level_q  <= {TXL_W{1'b0}};
    end else begin
      rx_level_q <= rx_level_d;
      tx_level_q <= tx_level_d;
      if (rx_wr_en_s) begin
        rx_wr_ptr_q <= rx_wr_ptr_q + RXA_W'(1);
      end
      if (rx_pop_s) begin
        rx_rd_ptr_q <= rx_rd_ptr_q + RXA_W'(1);
      end
      if (tx_push_s) begin
        tx_wr_ptr_q <= tx_wr_ptr_q + TXA_W'(1);
      end
      if (tx_rd_en_s) begin
        tx_rd_ptr_q <= tx_rd_ptr_q + TXA_W'(1);
      end
    end
  end

  // FIFO data arrays
  always_ff @(posedge clk) begin
    if (rx_wr_en_s) begin
      rx_mem_q[rx_wr_ptr_q] <= cap_q;
    end
    if (tx_push_s) begin
      tx_mem_q[tx_wr_ptr_q] <= tx_data;
    end
  end

  assign oe_n         = oe_n_q;
  assign rd_n         = rd_n_q;
  assign wr_n         = wr_n_q;
  assign ftdi_dout    = dout_q;
  assign ftdi_dout_en = dout_en_q;
  assign tx_ready     = !tx_full_s;
  assign tx_level     = tx_level_q;
  assign rx_valid     = !rx_empty_s;
  assign rx_data      = rx_mem_q[rx_rd_ptr_q];
  assign rx_level     = rx_level_q;
  assign rx_overflow  = overflow_q;

endmodule

// File: doc/ftdi_fifo_bridge.md
Name: ftdi_fifo_bridge

Overview:
Parametrised successor to the FT245-style FTDI controller. Runs the full asynchronous FIFO-interface protocol on the FTDI pins: oe_n, rd_n, wr_n, rxf_n, txe_n and a split data bus. Buffers traffic in two internal synchronous FIFOs and arbitrates fairly between read and write. Sits between the FTDI chip pins and the HSI packet logic; the local side uses valid/ready streams.

Parameters:
- DATA_W, 8: FTDI data bus and stream width.
- RX_DEPTH, 16: RX FIFO depth in words, FTDI to local. Power of two, at least 2.
- TX_DEPTH, 16: TX FIFO depth in words, local to FTDI. Power of two, at least 2.
- RD_CYCLES, 2: clocks rd_n is held low. At least 1.
- WR_CYCLES, 2: clocks wr_n is held low. At least 1.
- RECOVER_CYCLES, 2: clocks with the bus idle after each transfer before re-arbitration. At least 1.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous active-high reset.
- rxf_n, in, 1: FTDI has RX data when low.
- txe_n, in, 1: FTDI can accept TX data when low.
- oe_n, out, 1: FTDI output enable, active low.
- rd_n, out, 1: FTDI read strobe, active low.
- wr_n, out, 1: FTDI write strobe, active low.
- ftdi_din, in, DATA_W: bus value driven by the FTDI.
- ftdi_dout, out, DATA_W: bus value driven toward the FTDI.
- ftdi_dout_en, out, 1: tri-state enable for ftdi_dout at the pad level.
- tx_data, in, DATA_W: local word to send.
- tx_valid, in, 1: tx_data is valid.
- tx_ready, out, 1: TX FIFO not full.
- rx_data, out, DATA_W: head of the RX FIFO (show-ahead).
- rx_valid, out, 1: RX FIFO not empty.
- rx_ready, in, 1: local side consumes the head word.
- rx_level, out, clog2(RX_DEPTH+1): RX FIFO occupancy.
- tx_level, out, clog2(TX_DEPTH+1): TX FIFO occupancy.
- rx_overflow, out, 1: sticky flag.

Behaviour:
- Reset (async, rst=1):
  - oe_n=rd_n=wr_n=1, ftdi_dout_en=0, ftdi_dout=0.
  - Both FIFOs empty: levels 0, rx_valid=0, tx_ready=1.
  - rx_overflow=0; state IDLE; last_grant=TX, so RX wins the first tie.
  - Reset mid-strobe releases all strobes immediately and discards any partially transferred word.
- FIFOs:
  - Push on valid&&ready, pop on rx_valid&&rx_ready.
  - Simultaneous push and pop on a full or empty FIFO is legal. Level is unchanged when both occur; pointers wrap modulo depth.
  - tx_ready deasserts the cycle after the FIFO reaches TX_DEPTH.
- Arbitration in IDLE:
  - RX request: rxf_n=0 and rx_level<RX_DEPTH.
  - TX request: txe_n=0 and tx_level>0.
  - Both requesting: grant the side opposite to last_grant.
  - Neither requesting: stay in IDLE.
- Read sequence:
  - RD_OE: oe_n=0 for 1 clock.
  - RD_STROBE: rd_n=0 for RD_CYCLES clocks, oe_n stays 0. ftdi_din is captured on the last strobe clock and pushed to the RX FIFO on the next edge.
  - RD_RECOVER: rd_n=oe_n=1 for RECOVER_CYCLES clocks, then IDLE.
- Write sequence:
  - WR_SETUP: pop the TX head into ftdi_dout, ftdi_dout_en=1, wr_n=1, for 1 clock.
  - WR_STROBE: wr_n=0 for WR_CYCLES clocks.
  - WR_RECOVER: wr_n=1, data held for 1 clock, then ftdi_dout_en=0 for the remaining RECOVER_CYCLES-1 clocks, then IDLE.
- Bus safety: oe_n=0 and ftdi_dout_en=1 never overlap. There is at least one clock with both inactive between directions.
- Flag changes mid-sequence: rxf_n or txe_n deasserting after a grant does not abort the sequence; the transfer completes.
- rx_overflow: set if the RX FIFO is full at capture time. Arbitration prevents this, so the flag serves as a checker; the captured word is dropped.
- Minimum throughput: one word per 1+RD_CYCLES+RECOVER_CYCLES clocks (read) or 1+WR_CYCLES+RECOVER_CYCLES clocks (write).

Optional Feature:
- Macro: FTDI_INPUT_SYNC_EN.
- When defined: rxf_n and txe_n pass through two-flop synchronisers reset to 1. Arbitration sees them 2 clocks late, and RECOVER_CYCLES is internally extended by 2 so stale flags are never acted on.
- When undefined: the flags are used directly, and the FTDI side must be synchronous to clk.

Test Plan:
- Reset with rxf_n=0, txe_n=0 and the TX FIFO empty -> oe_n=rd_n=wr_n=1 held. After release, a read starts with oe_n=0 on the first clock.
- Single read, defaults: rxf_n=0, ftdi_din=8'hA5 -> oe_n low 3 clocks, rd_n low 2 clocks. Next cycle rx_valid=1, rx_data=8'hA5, rx_level=1.
- Write burst: push 8'h01..8'h04, txe_n=0 -> four wr_n pulses, each 2 clocks. ftdi_dout is stable from setup through recovery; tx_level ends at 0.
- Contention: rxf_n=0 and txe_n=0 with the TX FIFO holding 3 words -> grants alternate RX,TX,RX,TX, and oe_n and ftdi_dout_en never overlap.
- RX full: RX_DEPTH=4, rx_ready=0, rxf_n=0 -> exactly 4 reads, then IDLE and rd_n stays 1, rx_overflow=0. A single rx_ready pulse then allows exactly 1 more read.
- Async reset asserted during WR_STROBE -> wr_n=1 and ftdi_dout_en=0 within the same cycle, and tx_level=0.
